// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants, state type and sizing helper for the BCD <-> binary converters.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] CORR_SUB    = 4'd3;
  localparam logic [DIGIT_W-1:0] FWD_THRESH  = 4'd5;
  localparam logic [DIGIT_W-1:0] FWD_ADD     = 4'd3;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Smallest binary width that can hold every value of a DIGITS-digit decimal number.
  function automatic int min_bin_w(input int digits);
    longint unsigned limit;
    int w;
    limit = 1;
    for (int i = 0; i < digits; i++) limit = limit * 10;
    w = 0;
    while ((64'd1 << w) < limit) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready bundle for the BCD-to-binary converter: BCD request in, binary result out.
interface bcd2bin_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIGIT_W*DIGITS-1:0] bcd;
  logic                      out_valid;
  logic                      out_ready;
  logic [BIN_W-1:0]          bin;
  logic                      err;

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, bin, err
  );

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, bin, err
  );
endinterface

// File: rtl/bcd2bin_seq_digit_corr.sv
// Reverse double-dabble digit fix-up: a digit that reached 8 or more after the shift loses 3.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);
  assign d_o = (d_i >= CORR_THRESH) ? (d_i - CORR_SUB) : d_i;
endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter (one right shift plus digit correction per clock).
// Optional macro BCD2BIN_CHECK_EN flags input digits above 9 on err.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10,
  parameter int CNT_W  = 4
) (
  input logic           clk,
  input logic           rst,
  bcd2bin_seq_if.slave  bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [SR_W-1:0]   sr_shift;
  logic [BCD_W-1:0]  corr_field;
  logic [SR_W-1:0]   sr_corr;

  // Binary bits leave the bottom of the BCD field; the digits are then re-normalised.
  assign sr_shift = sr_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d_i (sr_shift[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .d_o (corr_field[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign sr_corr = {corr_field, sr_shift[BIN_W-1:0]};

`ifdef BCD2BIN_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
`ifdef BCD2BIN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = {bus.bcd, {BIN_W{1'b0}}};
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BCD2BIN_CHECK_EN
          err_d   = bad_digit;
`endif
        end
      end
      SHIFT: begin
        sr_d  = sr_corr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bin_d   = sr_corr[BIN_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin       = bin_q;
`ifdef BCD2BIN_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
